// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline freeze/stall/flush sequencer with memory wait FSM
// Also keeps saturating performance counters for stall and flush cycles.
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT = 6,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FW_EN,
  input  logic [4:0]       ID_src1,
  input  logic [4:0]       ID_src2,
  input  logic             ID_two_src,
  input  logic [4:0]       EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [4:0]       MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             MEM_access,
  input  logic             Br_taken,
  output logic             freeze_all,
  output logic             hazard_stall,
  output logic             flush,
  output logic             mem_ready,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // The IDLE cycle that accepts the access is already frozen, hence the -2.
  localparam logic [7:0]       WAIT_LOAD = 8'(MEM_WAIT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       raw;

  function automatic logic reg_match(input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic two_src);
    return (d != 5'd0) && ((d == s1) || (two_src && (d == s2)));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_access) begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt == 8'd0) state <= DONE;
          else                  wait_cnt <= wait_cnt - 8'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    if (FW_EN)
      raw = EXE_WB_EN && EXE_MEM_R_EN && reg_match(EXE_Dest, ID_src1, ID_src2, ID_two_src);
    else
      raw = (EXE_WB_EN && reg_match(EXE_Dest, ID_src1, ID_src2, ID_two_src)) ||
            (MEM_WB_EN && reg_match(MEM_Dest, ID_src1, ID_src2, ID_two_src));
  end

  // Reset gates every control so nothing leaks out while rst is high.
  assign freeze_all   = !rst && (((state == IDLE) && MEM_access) || (state == WAIT));
  assign mem_ready    = !rst && (state == DONE);
  assign flush        = !rst && Br_taken && !freeze_all;
  assign hazard_stall = !rst && raw && !freeze_all && !Br_taken;
  assign ctrl_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != CNT_MAX))        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       FW_EN;
  logic [4:0] ID_src1, ID_src2, EXE_Dest, MEM_Dest;
  logic       ID_two_src, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN, MEM_access, Br_taken;
  logic       freeze_all, hazard_stall, flush, mem_ready;
  logic [1:0] ctrl_state;
  logic [15:0] stall_cnt, flush_cnt;
  logic       s_freeze_all, s_hazard_stall, s_flush, s_mem_ready;
  logic [1:0] s_ctrl_state;
  logic [2:0] s_stall_cnt, s_flush_cnt;

  int checks;
  int failures;

  pipeline_hazard_ctrl #(.MEM_WAIT(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .FW_EN(FW_EN), .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_two_src(ID_two_src), .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN),
    .EXE_MEM_R_EN(EXE_MEM_R_EN), .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
    .MEM_access(MEM_access), .Br_taken(Br_taken), .freeze_all(freeze_all),
    .hazard_stall(hazard_stall), .flush(flush), .mem_ready(mem_ready),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
  pipeline_hazard_ctrl #(.MEM_WAIT(6), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .FW_EN(FW_EN), .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_two_src(ID_two_src), .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN),
    .EXE_MEM_R_EN(EXE_MEM_R_EN), .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
    .MEM_access(MEM_access), .Br_taken(Br_taken), .freeze_all(s_freeze_all),
    .hazard_stall(s_hazard_stall), .flush(s_flush), .mem_ready(s_mem_ready),
    .ctrl_state(s_ctrl_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_hazard();
    FW_EN = 1'b1; ID_src1 = 5'd0; ID_src2 = 5'd0; ID_two_src = 1'b0;
    EXE_Dest = 5'd0; EXE_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0;
    MEM_Dest = 5'd0; MEM_WB_EN = 1'b0; Br_taken = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (ctrl_state == 2'd0 && !freeze_all) break;
    end
    check("idle_reached", {30'd0, ctrl_state}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    // Reset with every trigger asserted, including a load-use hazard.
    rst = 1'b1;
    clear_hazard();
    MEM_access = 1'b1; Br_taken = 1'b1;
    EXE_MEM_R_EN = 1'b1; EXE_WB_EN = 1'b1; EXE_Dest = 5'd5; ID_src1 = 5'd5;
    #2;
    check("rst_freeze", freeze_all, 0);
    check("rst_stall", hazard_stall, 0);
    check("rst_flush", flush, 0);
    check("rst_ready", mem_ready, 0);
    check("rst_state", ctrl_state, 0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);

    // Memory wait: 6 frozen cycles then one DONE cycle, then immediate re-trigger.
    @(negedge clk);
    rst = 1'b0;
    clear_hazard();
    MEM_access = 1'b1;
    #1;
    check("mw_c1_freeze", freeze_all, 1);
    check("mw_c1_state", ctrl_state, 0);
    check("mw_c1_ready", mem_ready, 0);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk); #1;
      check($sformatf("mw_c%0d_freeze", c), freeze_all, 1);
      check($sformatf("mw_c%0d_state", c), ctrl_state, 1);
      check($sformatf("mw_c%0d_ready", c), mem_ready, 0);
    end
    @(negedge clk); #1;
    check("mw_c7_freeze", freeze_all, 0);
    check("mw_c7_state", ctrl_state, 2);
    check("mw_c7_ready", mem_ready, 1);
    @(negedge clk); #1;
    check("mw_c8_state", ctrl_state, 0);
    check("mw_c8_freeze", freeze_all, 1);
    MEM_access = 1'b0;
    wait_idle();

    // Load-use with forwarding.
    FW_EN = 1'b1; EXE_MEM_R_EN = 1'b1; EXE_WB_EN = 1'b1; EXE_Dest = 5'd5;
    ID_src1 = 5'd3; ID_src2 = 5'd5; ID_two_src = 1'b1;
    #1;
    check("lu_stall", hazard_stall, 1);
    check("lu_cnt0", stall_cnt, 0);
    @(negedge clk);
    ID_two_src = 1'b0;
    #1;
    check("lu_one_src_stall", hazard_stall, 0);
    check("lu_cnt1", stall_cnt, 1);
    ID_two_src = 1'b1; EXE_MEM_R_EN = 1'b0;
    #1;
    check("fw_nonload_stall", hazard_stall, 0);

    // No forwarding: MEM match, register 0, EXE non-load match.
    @(negedge clk);
    clear_hazard();
    FW_EN = 1'b0; MEM_WB_EN = 1'b1; MEM_Dest = 5'd7; ID_src1 = 5'd7;
    #1;
    check("nf_mem_stall", hazard_stall, 1);
    @(negedge clk);
    MEM_Dest = 5'd0; ID_src1 = 5'd0;
    #1;
    check("nf_r0_stall", hazard_stall, 0);
    check("nf_cnt2", stall_cnt, 2);
    @(negedge clk);
    MEM_WB_EN = 1'b0; EXE_WB_EN = 1'b1; EXE_Dest = 5'd9; ID_src1 = 5'd9;
    #1;
    check("nf_exe_stall", hazard_stall, 1);

    // Branch outranks hazard.
    @(negedge clk);
    Br_taken = 1'b1;
    #1;
    check("pr_flush", flush, 1);
    check("pr_stall", hazard_stall, 0);
    check("pr_stall_cnt", stall_cnt, 3);
    @(negedge clk);
    clear_hazard();
    #1;
    check("pr_flush_cnt", flush_cnt, 1);
    check("pr_stall_cnt_hold", stall_cnt, 3);

    // Branch held through a memory freeze flushes only in DONE.
    Br_taken = 1'b1; MEM_access = 1'b1;
    #1;
    check("bw_c1_flush", flush, 0);
    check("bw_c1_freeze", freeze_all, 1);
    @(negedge clk);
    MEM_access = 1'b0;
    #1;
    check("bw_c2_flush", flush, 0);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk); #1;
      check($sformatf("bw_c%0d_flush", c), flush, 0);
    end
    @(negedge clk); #1;
    check("bw_done_state", ctrl_state, 2);
    check("bw_done_flush", flush, 1);
    @(negedge clk);
    Br_taken = 1'b0;
    #1;
    check("bw_flush_cnt", flush_cnt, 2);
    check("bw_state_idle", ctrl_state, 0);

    // Saturation: narrow counter starts at 3, eight more stalls clamp it at 7.
    FW_EN = 1'b1; EXE_MEM_R_EN = 1'b1; EXE_WB_EN = 1'b1; EXE_Dest = 5'd4; ID_src1 = 5'd4;
    repeat (8) @(negedge clk);
    #1;
    check("sat_small_cnt", s_stall_cnt, 7);
    check("sat_wide_cnt", stall_cnt, 11);
    check("sat_small_flush", s_flush_cnt, 2);

    // Reset in WAIT with counter at 3.
    clear_hazard();
    MEM_access = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rw_pre_state", ctrl_state, 1);
    check("rw_pre_freeze", freeze_all, 1);
    rst = 1'b1;
    #1;
    check("rw_freeze", freeze_all, 0);
    check("rw_state", ctrl_state, 0);
    check("rw_stall_cnt", stall_cnt, 0);
    check("rw_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    MEM_access = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
